// File: rtl/alu_pkg.sv
// Shared types for the pipelined carry-lookahead ALU: op codes, flag bundle
// and the lookahead group width.
package alu_pkg;

    localparam int GROUP_W = 4;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SLT  = 3'b101,
        OP_SLTU = 3'b110,
        OP_RSV  = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } alu_flags_t;

    // Ops that run the adder as a + ~b + 1.
    function automatic logic op_inverts_b(input alu_op_t op);
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    endfunction

endpackage

// File: rtl/pipelined_cla_alu_cla_group.sv
// 4-bit carry-lookahead group: sum, bitwise results and group generate/propagate.
module cla_group (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic [3:0] o_and,
    output logic [3:0] o_or,
    output logic [3:0] o_xor,
    output logic       o_g,
    output logic       o_p,
    output logic       o_cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_g    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_p    = &w_p;
    assign o_cout = o_g | (o_p & i_cin);

    assign o_sum = w_p ^ w_c;
    assign o_and = w_g;
    assign o_or  = i_a | i_b;
    assign o_xor = w_p;

endmodule

// File: rtl/pipelined_cla_alu.sv
// Pipelined RV32I integer ALU: carry chain cut into STAGES register slices,
// valid/ready handshake with a single global advance enable.
module pipelined_cla_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n
);
    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / GROUP_W;

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_result;
    alu_flags_t        r_flags;
    logic              w_adv;

    assign w_adv     = !r_valid[STAGES-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_valid[STAGES-1];
    assign result    = r_result;
    assign flag_c    = r_flags.c;
    assign flag_v    = r_flags.v;
    assign flag_z    = r_flags.z;
    assign flag_n    = r_flags.n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_adv) begin
            r_valid <= STAGES'({r_valid, in_valid});
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        localparam int LO = k * SW;
        localparam int HI = WIDTH - LO - SW;

        logic [SW-1:0]    w_a, w_b, w_bx, w_sum, w_and, w_or, w_xor, w_res;
        logic [LO+SW-1:0] w_acc;
        alu_op_t          w_op;
        logic             w_cin, w_cout, w_sg, w_sp;
        logic [NG-1:0]    w_c, w_g, w_p, w_gco;

        // Slice 0 works straight off the ports; later slices off the previous register.
        if (k == 0) begin : g_src
            assign w_a   = a[SW-1:0];
            assign w_b   = b[SW-1:0];
            assign w_op  = alu_op_t'(op);
            assign w_cin = op_inverts_b(alu_op_t'(op));
            assign w_acc = w_res;
        end else begin : g_src
            assign w_a   = g_slice[k-1].g_fwd.r_a[SW-1:0];
            assign w_b   = g_slice[k-1].g_fwd.r_b[SW-1:0];
            assign w_op  = g_slice[k-1].g_fwd.r_op;
            assign w_cin = g_slice[k-1].g_fwd.r_carry;
            assign w_acc = {w_res, g_slice[k-1].g_fwd.r_res};
        end

        assign w_bx   = op_inverts_b(w_op) ? ~w_b : w_b;
        assign w_c[0] = w_cin;

        for (genvar g = 0; g < NG; g++) begin : g_grp
            cla_group u_cla (
                .i_a    (w_a[g*GROUP_W +: GROUP_W]),
                .i_b    (w_bx[g*GROUP_W +: GROUP_W]),
                .i_cin  (w_c[g]),
                .o_sum  (w_sum[g*GROUP_W +: GROUP_W]),
                .o_and  (w_and[g*GROUP_W +: GROUP_W]),
                .o_or   (w_or[g*GROUP_W +: GROUP_W]),
                .o_xor  (w_xor[g*GROUP_W +: GROUP_W]),
                .o_g    (w_g[g]),
                .o_p    (w_p[g]),
                .o_cout (w_gco[g])
            );
            if (g > 0) begin : g_link
                assign w_c[g] = w_gco[g-1];
            end
        end

        // Slice carry-out comes from block-level lookahead over the group G/P terms.
        always_comb begin
            w_sg = 1'b0;
            w_sp = 1'b1;
            for (int unsigned i = 0; i < NG; i++) begin
                w_sg = w_g[i] | (w_p[i] & w_sg);
                w_sp = w_sp & w_p[i];
            end
        end
        assign w_cout = w_sg | (w_sp & w_cin);

        always_comb begin
            unique case (w_op)
                OP_AND:  w_res = w_and;
                OP_OR:   w_res = w_or;
                OP_XOR:  w_res = w_xor;
                default: w_res = w_sum;
            endcase
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [HI-1:0]    r_a, r_b, w_a_up, w_b_up;
            logic [LO+SW-1:0] r_res;
            alu_op_t          r_op;
            logic             r_carry;

            if (k == 0) begin : g_up
                assign w_a_up = a[WIDTH-1:SW];
                assign w_b_up = b[WIDTH-1:SW];
            end else begin : g_up
                assign w_a_up = g_slice[k-1].g_fwd.r_a[HI+SW-1:SW];
                assign w_b_up = g_slice[k-1].g_fwd.r_b[HI+SW-1:SW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a     <= '0;
                    r_b     <= '0;
                    r_res   <= '0;
                    r_op    <= OP_ADD;
                    r_carry <= 1'b0;
                end else if (w_adv) begin
                    r_a     <= w_a_up;
                    r_b     <= w_b_up;
                    r_res   <= w_acc;
                    r_op    <= w_op;
                    r_carry <= w_cout;
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] w_result;
            alu_flags_t       w_flags;
            logic             w_v;

            always_comb begin
                w_v      = (w_a[SW-1] == w_bx[SW-1]) && (w_sum[SW-1] != w_a[SW-1]);
                w_result = w_acc;
                w_flags  = '0;
                unique case (w_op)
                    OP_ADD, OP_SUB: begin
                        w_flags.c = w_cout;
                        w_flags.v = w_v;
                    end
                    OP_SLT: begin
                        w_result  = WIDTH'(w_sum[SW-1] ^ w_v);
                        w_flags.c = w_cout;
                        w_flags.v = w_v;
                    end
                    OP_SLTU: begin
                        w_result  = WIDTH'(!w_cout);
                        w_flags.c = w_cout;
                        w_flags.v = w_v;
                    end
                    OP_RSV:  w_result = '0;
                    default: ;
                endcase
                w_flags.z = (w_result == '0);
                w_flags.n = w_result[WIDTH-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_result <= '0;
                    r_flags  <= '0;
                end else if (w_adv) begin
                    r_result <= w_result;
                    r_flags  <= w_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_alu.sv
// Self-checking bench for pipelined_cla_alu: directed vectors, stall, reset
// and randomized traffic against an arithmetic reference model.
module tb_pipelined_cla_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        flag_c, flag_v, flag_z, flag_n;

    pipelined_cla_alu #(.WIDTH(32), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_z    (flag_z),
        .flag_n    (flag_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic; flags packed {c,v,z,n}.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t            e;
        longint          sx, sy, sr;
        longint unsigned ux, uy;
        logic            c, v;
        logic [31:0]     r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        c  = 1'b0;
        v  = 1'b0;
        r  = '0;
        case (o)
            3'd0: begin
                r  = x + y;
                c  = (ux + uy) > 64'h0000_0000_FFFF_FFFF;
                sr = sx + sy;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd1, 3'd5, 3'd6: begin
                r  = x - y;
                c  = (ux >= uy);
                sr = sx - sy;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                if (o == 3'd5) r = (sx < sy) ? 32'd1 : 32'd0;
                if (o == 3'd6) r = (ux < uy) ? 32'd1 : 32'd0;
            end
            3'd2:    r = x & y;
            3'd3:    r = x | y;
            3'd4:    r = x ^ y;
            default: r = '0;
        endcase
        e.res = r;
        e.fl  = {c, v, (r == 32'd0), r[31]};
        return e;
    endfunction

    // One clock: drive at the falling edge, then record the handshakes the next rising edge performs.
    task automatic cycle(input logic v, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic ordy, output logic accepted);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        op        = o;
        a         = x;
        b         = y;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            n_done++;
            if (q.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                check("sb_result", result, e.res);
                check("sb_flags", {flag_c, flag_v, flag_z, flag_n}, e.fl);
            end
        end
        accepted = v && in_ready;
        if (accepted) q.push_back(model(o, x, y));
    endtask

    task automatic directed(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] er, input logic [3:0] ef);
        logic        acc;
        int          lat;
        logic [31:0] got_res;
        logic [3:0]  got_fl;
        lat     = 0;
        got_res = 'x;
        got_fl  = 'x;
        cycle(1'b1, o, x, y, 1'b1, acc);
        check({tag, "_accept"}, acc, 1);
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, acc);
            if (out_valid) begin
                lat     = i;
                got_res = result;
                got_fl  = {flag_c, flag_v, flag_z, flag_n};
            end
        end
        check({tag, "_latency"}, lat, 2);
        check({tag, "_result"}, got_res, er);
        check({tag, "_flags"}, got_fl, ef);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'h7FFF_FFFF;
        corners[4] = 32'h0000_0001;
        if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
        return $urandom;
    endfunction

    initial begin
        logic        acc;
        int          sent;
        int          done0;
        logic        prev_st;
        logic [35:0] held;
        logic [31:0] ra, rb;

        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_flags", {flag_c, flag_v, flag_z, flag_n}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", in_ready, 1);

        directed("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010);
        directed("sub_neg",  OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0001);
        directed("add_ovf",  OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101);
        directed("slt",      OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b1000);
        directed("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010);
        directed("reserved", OP_RSV, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 4'b0010);
        directed("and",      OP_AND, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'h00F0_A5A5, 4'b0000);
        directed("or",       OP_OR,  32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 4'b0001);
        directed("xor",      OP_XOR, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFF00_5A5A, 4'b0001);

        // Eight back-to-back adds with the consumer stalled for three cycles.
        sent    = 0;
        done0   = n_done;
        prev_st = 1'b0;
        held    = '0;
        for (int c = 0; c < 40 && (sent < 8 || q.size() > 0); c++) begin
            cycle(sent < 8, OP_ADD, 32'h0100_0000 + sent, 32'h0000_0033 * sent,
                  !(c >= 4 && c <= 6), acc);
            if (acc) sent++;
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 0);
                if (prev_st) check("stall_hold", {result, flag_c, flag_v, flag_z, flag_n}, held);
                held    = {result, flag_c, flag_v, flag_z, flag_n};
                prev_st = 1'b1;
            end else begin
                prev_st = 1'b0;
            end
        end
        check("stall_sent", sent, 8);
        check("stall_completed", n_done - done0, 8);
        check("stall_drained", q.size(), 0);

        // Randomized traffic with random backpressure and bubbles.
        for (int c = 0; c < 400; c++) begin
            ra = pick_operand();
            rb = pick_operand();
            cycle($urandom_range(3) != 0, 3'($urandom_range(7)), ra, rb, $urandom_range(9) < 7, acc);
        end
        for (int c = 0; c < 20 && q.size() > 0; c++) cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, acc);
        check("random_drained", q.size(), 0);

        // Asynchronous reset with two ops in flight.
        cycle(1'b1, OP_ADD, 32'h1111_1111, 32'h2222_2222, 1'b0, acc);
        cycle(1'b1, OP_SUB, 32'h3333_3333, 32'h0000_0001, 1'b0, acc);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, acc);
        check("pre_reset_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_result", result, 0);
        check("async_flags", {flag_c, flag_v, flag_z, flag_n}, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", in_ready, 1);
        directed("post_reset_add", OP_ADD, 32'd3, 32'd4, 32'd7, 4'b0000);
        check("post_reset_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
